// File: rtl/adxl345_pkg.sv
// Shared constants, FSM state type and frame builder
// for the ADXL345 SPI master.
package adxl345_pkg;

  localparam logic [5:0] ADXL345_DEVID_ADDR  = 6'h00;
  localparam logic [7:0] ADXL345_DEVID_VALUE = 8'hE5;
  localparam int         ADXL345_FRAME_BITS  = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CS_SETUP,
    ST_SCK_LOW,
    ST_SCK_HIGH,
    ST_CS_HOLD,
    ST_CS_GAP,
    ST_BOOT
  } adxl345_spi_state_t;

  function automatic logic [15:0] adxl345_frame(
    input logic       rw,
    input logic [5:0] addr,
    input logic [7:0] wdata
  );
    return {rw, 1'b0, addr, rw ? 8'h00 : wdata};
  endfunction

endpackage

// File: rtl/spi_interface.sv
// Four-wire SPI bus bundle with master and slave views.
interface spi_interface;

  logic cs;
  logic sck;
  logic mosi;
  logic miso;

  modport Master (output cs, sck, mosi, input miso);
  modport Slave  (input cs, sck, mosi, output miso);

endinterface

// File: rtl/adxl345_spi_master_clk_div.sv
// SCK half-period timer: one-cycle tick every CLK_DIV
// cycles while enabled, cleared while disabled.
module spi_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == CW'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/adxl345_spi_master.sv
// Mode-3 SPI master for single-register ADXL345 access.
// ADXL345_SPI_DEVID_CHECK_EN adds a DEVID read after reset.
module adxl345_spi_master
  import adxl345_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  spi_interface.Master spi_bus,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rw,
  input  logic [5:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       dev_ok,
  output logic       dev_err
);

  if (CLK_DIV < 2) begin : g_bad_div
    $error("adxl345_spi_master: CLK_DIV must be >= 2");
  end

`ifdef ADXL345_SPI_DEVID_CHECK_EN
  localparam adxl345_spi_state_t RST_STATE = ST_BOOT;
  localparam logic READY_RST = 1'b0;
`else
  localparam adxl345_spi_state_t RST_STATE = ST_IDLE;
  localparam logic READY_RST = 1'b1;
`endif

  localparam logic [3:0] LAST_BIT =
    4'(ADXL345_FRAME_BITS - 1);

  adxl345_spi_state_t state, state_n;

  logic        tick;
  logic        tick_q;
  logic        accept;
  logic        div_en;
  logic        done;
  logic        booting;
  logic [15:0] shift;
  logic [3:0]  bit_cnt;

  logic       cs_q, sck_q, mosi_q, ready_q, rsp_q;
  logic [7:0] rdata_q;
  logic       cs_d, sck_d, mosi_d, ready_d;

  assign accept = req_valid && ready_q;
  assign div_en = !(state inside {ST_IDLE, ST_BOOT});
  // tick_q marks the first cycle of a tick-entered state
  assign done   = (state == ST_CS_GAP) && tick_q;

  spi_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (div_en),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= RST_STATE;
      tick_q <= 1'b0;
    end else begin
      state  <= state_n;
      tick_q <= tick;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE:
        if (accept) state_n = ST_CS_SETUP;
      ST_BOOT:
        state_n = ST_CS_SETUP;
      ST_CS_SETUP:
        if (tick) state_n = ST_SCK_LOW;
      ST_SCK_LOW:
        if (tick) state_n = ST_SCK_HIGH;
      ST_SCK_HIGH:
        if (tick) begin
          if (bit_cnt == '0) state_n = ST_CS_HOLD;
          else               state_n = ST_SCK_LOW;
        end
      ST_CS_HOLD:
        if (tick) state_n = ST_CS_GAP;
      ST_CS_GAP:
        if (tick) state_n = ST_IDLE;
      default:
        state_n = ST_IDLE;
    endcase
  end

  // frame leaves from the top while miso enters at the bottom
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift <= '0;
    end else if (accept) begin
      shift <= adxl345_frame(req_rw, req_addr, req_wdata);
    end else if (state == ST_BOOT) begin
      shift <= adxl345_frame(1'b1, ADXL345_DEVID_ADDR,
                             8'h00);
    end else if (state == ST_SCK_HIGH && tick_q) begin
      shift <= {shift[14:0], spi_bus.miso};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= '0;
    end else if (accept || state == ST_BOOT) begin
      bit_cnt <= LAST_BIT;
    end else if (state == ST_SCK_HIGH && tick
                 && bit_cnt != '0) begin
      bit_cnt <= bit_cnt - 4'd1;
    end
  end

  always_comb begin
    cs_d    = state inside {ST_IDLE, ST_CS_GAP, ST_BOOT};
    sck_d   = state != ST_SCK_LOW;
    mosi_d  = (state == ST_SCK_LOW) ? shift[15] : mosi_q;
    ready_d = (state == ST_IDLE) && !accept;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_q    <= 1'b1;
      sck_q   <= 1'b1;
      mosi_q  <= 1'b0;
      ready_q <= READY_RST;
      rsp_q   <= 1'b0;
      rdata_q <= 8'h00;
    end else begin
      cs_q    <= cs_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      ready_q <= ready_d;
      rsp_q   <= done && !booting;
      if (done && !booting) rdata_q <= shift[7:0];
    end
  end

`ifdef ADXL345_SPI_DEVID_CHECK_EN
  logic boot_q, ok_q, err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      boot_q <= 1'b1;
      ok_q   <= 1'b0;
      err_q  <= 1'b0;
    end else if (done && boot_q) begin
      boot_q <= 1'b0;
      ok_q   <= shift[7:0] == ADXL345_DEVID_VALUE;
      err_q  <= shift[7:0] != ADXL345_DEVID_VALUE;
    end
  end

  assign booting = boot_q;
  assign dev_ok  = ok_q;
  assign dev_err = err_q;
`else
  assign booting = 1'b0;
  assign dev_ok  = 1'b0;
  assign dev_err = 1'b0;
`endif

  assign spi_bus.cs   = cs_q;
  assign spi_bus.sck  = sck_q;
  assign spi_bus.mosi = mosi_q;
  assign req_ready    = ready_q;
  assign rsp_valid    = rsp_q;
  assign rsp_rdata    = rdata_q;

endmodule

// File: tb/tb_adxl345_spi_master.sv
// Directed bench for adxl345_spi_master with a behavioural
// ADXL345 slave shared by a CLK_DIV=4 and a CLK_DIV=2 instance.
`timescale 1ns/1ps
module tb_adxl345_spi_master;

`ifdef ADXL345_SPI_DEVID_CHECK_EN
  localparam bit BOOT_EN = 1'b1;
`else
  localparam bit BOOT_EN = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic rst2_n = 1'b1;
  logic use2 = 1'b0;

  logic       req_valid = 1'b0;
  logic       req_rw = 1'b0;
  logic [5:0] req_addr = '0;
  logic [7:0] req_wdata = '0;

  logic       ready4, rsp4, ok4, err4;
  logic       ready2, rsp2, ok2, err2;
  logic [7:0] rdata4, rdata2;

  logic       ready, rsp_v, dev_ok, dev_err;
  logic [7:0] rdata;
  logic       m_cs, m_sck, m_mosi;
  logic       m_miso = 1'b0;

  spi_interface bus4 ();
  spi_interface bus2 ();

  always #5 clk = ~clk;

  adxl345_spi_master #(.CLK_DIV(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .spi_bus   (bus4),
    .req_valid (req_valid && !use2),
    .req_ready (ready4),
    .req_rw    (req_rw),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp4),
    .rsp_rdata (rdata4),
    .dev_ok    (ok4),
    .dev_err   (err4)
  );

  adxl345_spi_master #(.CLK_DIV(2)) dut2 (
    .clk       (clk),
    .rst_n     (rst2_n),
    .spi_bus   (bus2),
    .req_valid (req_valid && use2),
    .req_ready (ready2),
    .req_rw    (req_rw),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp2),
    .rsp_rdata (rdata2),
    .dev_ok    (ok2),
    .dev_err   (err2)
  );

  assign bus4.miso = m_miso;
  assign bus2.miso = m_miso;
  assign m_cs    = use2 ? bus2.cs   : bus4.cs;
  assign m_sck   = use2 ? bus2.sck  : bus4.sck;
  assign m_mosi  = use2 ? bus2.mosi : bus4.mosi;
  assign ready   = use2 ? ready2 : ready4;
  assign rsp_v   = use2 ? rsp2   : rsp4;
  assign rdata   = use2 ? rdata2 : rdata4;
  assign dev_ok  = use2 ? ok2    : ok4;
  assign dev_err = use2 ? err2   : err4;

  // behavioural ADXL345: mode 3, register file of 64 bytes
  logic [7:0]  m_regs [64];
  logic [15:0] m_rx = '0;
  logic [15:0] m_frame = '0;
  logic [7:0]  m_tx = '0;
  int          m_bits = 0;
  int          m_rises = 0;

  always @(negedge m_cs) begin
    m_bits = 0;
    m_rx   = '0;
  end

  always @(posedge m_sck) if (!m_cs) begin
    m_rx = {m_rx[14:0], m_mosi};
    m_bits++;
    m_rises++;
    if (m_bits == 8) m_tx = m_regs[m_rx[5:0]];
    if (m_bits == 16) begin
      m_frame = m_rx;
      if (!m_rx[15]) m_regs[m_rx[13:8]] = m_rx[7:0];
    end
  end

  always @(negedge m_sck) if (!m_cs) begin
    if (m_bits >= 8 && m_bits < 16)
      m_miso = m_tx[3'(15 - m_bits)];
    else
      m_miso = 1'b0;
  end

  int   rsp_total = 0;
  bit   dbl_rsp = 1'b0;
  bit   mosi_glitch = 1'b0;
  logic prev_rsp = 1'b0;
  logic prev_sck = 1'b1;
  logic prev_mosi = 1'b0;

  always @(negedge clk) begin
    if (rsp_v && prev_rsp) dbl_rsp = 1'b1;
    if (rsp_v) rsp_total++;
    if (!m_cs && m_sck && prev_sck && m_mosi !== prev_mosi)
      mosi_glitch = 1'b1;
    prev_rsp  = rsp_v;
    prev_sck  = m_sck;
    prev_mosi = m_mosi;
  end

  task automatic run_frame(
    input  logic       rw,
    input  logic [5:0] addr,
    input  logic [7:0] wd,
    output int t_cs, output int t_sck, output int t_sck2,
    output int t_rise, output int t_rsp, output int n_rsp,
    output int t_rdy, output int cs_low,
    output logic [7:0] rd
  );
    logic ps;
    ps = 1'b1;
    t_cs = -1; t_sck = -1; t_sck2 = -1; t_rise = -1;
    t_rsp = -1; n_rsp = 0; t_rdy = -1; cs_low = 0;
    rd = 8'h00;
    @(negedge clk);
    req_rw = rw; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int n = 0; n < 600 && t_rdy < 0; n++) begin
      @(negedge clk);
      if (!m_cs) begin
        cs_low++;
        if (t_cs < 0) t_cs = n;
      end
      if (ps && !m_sck) begin
        if (t_sck < 0) t_sck = n;
        else if (t_sck2 < 0) t_sck2 = n;
      end
      if (!ps && m_sck && t_rise < 0) t_rise = n;
      ps = m_sck;
      if (rsp_v) begin
        n_rsp++;
        if (t_rsp < 0) begin
          t_rsp = n;
          rd = rdata;
        end
      end
      if (t_rsp >= 0 && ready) t_rdy = n;
    end
  endtask

  task automatic wait_ready(output int t);
    t = -1;
    for (int n = 0; n < 400 && t < 0; n++) begin
      @(negedge clk);
      if (ready) t = n;
    end
  endtask

  task automatic test_reset;
    int t;
    #1 rst_n = 1'b0;
    rst2_n = 1'b0;
    #1;
    checks++;
    if (m_cs !== 1'b1) begin
      errors++; $display("FAIL rst_cs: got %b want 1", m_cs);
    end
    checks++;
    if (m_sck !== 1'b1) begin
      errors++; $display("FAIL rst_sck: got %b want 1", m_sck);
    end
    checks++;
    if (m_mosi !== 1'b0) begin
      errors++; $display("FAIL rst_mosi: got %b want 0", m_mosi);
    end
    checks++;
    if (rsp_v !== 1'b0) begin
      errors++; $display("FAIL rst_rsp: got %b want 0", rsp_v);
    end
    checks++;
    if (rdata !== 8'h00) begin
      errors++; $display("FAIL rst_rdata: got %h want 00", rdata);
    end
    checks++;
    if (dev_ok !== 1'b0 || dev_err !== 1'b0) begin
      errors++;
      $display("FAIL rst_dev: got ok=%b err=%b want 0/0",
               dev_ok, dev_err);
    end
    checks++;
    if (ready !== !BOOT_EN) begin
      errors++;
      $display("FAIL rst_ready: got %b want %b", ready, !BOOT_EN);
    end
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready(t);
`ifdef ADXL345_SPI_DEVID_CHECK_EN
    checks++;
    if (t != 1 + 35 * 4) begin
      errors++; $display("FAIL boot_ready: got %0d want 141", t);
    end
    checks++;
    if (dev_ok !== 1'b1 || dev_err !== 1'b0) begin
      errors++;
      $display("FAIL boot_ok: got ok=%b err=%b want 1/0",
               dev_ok, dev_err);
    end
    checks++;
    if (rsp_total != 0) begin
      errors++; $display("FAIL boot_rsp: got %0d want 0", rsp_total);
    end
`else
    checks++;
    if (t != 0) begin
      errors++; $display("FAIL idle_ready: got %0d want 0", t);
    end
`endif
  endtask

  task automatic test_read(input int d, input int f);
    int t_cs, t_sck, t_sck2, t_rise, t_rsp, n_rsp, t_rdy, cs_low;
    logic [7:0] rd;
    run_frame(1'b1, 6'h00, 8'h5A, t_cs, t_sck, t_sck2, t_rise,
              t_rsp, n_rsp, t_rdy, cs_low, rd);
    checks++;
    if (m_frame !== 16'h8000) begin
      errors++;
      $display("FAIL rd%0d_frame: got %h want 8000", f, m_frame);
    end
    checks++;
    if (rd !== 8'hE5) begin
      errors++; $display("FAIL rd%0d_data: got %h want e5", f, rd);
    end
    checks++;
    if (t_cs != 1 || t_sck != 1 + d) begin
      errors++;
      $display("FAIL rd%0d_start: got cs=%0d sck=%0d want 1/%0d",
               f, t_cs, t_sck, 1 + d);
    end
    checks++;
    if (t_sck2 - t_sck != 2 * d || t_rise - t_sck != d) begin
      errors++;
      $display("FAIL rd%0d_sck: got per=%0d low=%0d want %0d/%0d",
               f, t_sck2 - t_sck, t_rise - t_sck, 2 * d, d);
    end
    checks++;
    if (t_rsp != 1 + 34 * d || n_rsp != 1) begin
      errors++;
      $display("FAIL rd%0d_rsp: got t=%0d n=%0d want %0d/1",
               f, t_rsp, n_rsp, 1 + 34 * d);
    end
    checks++;
    if (t_rdy != 1 + 35 * d) begin
      errors++;
      $display("FAIL rd%0d_ready: got %0d want %0d",
               f, t_rdy, 1 + 35 * d);
    end
  endtask

  task automatic test_write;
    int t_cs, t_sck, t_sck2, t_rise, t_rsp, n_rsp, t_rdy, cs_low;
    int r0;
    logic [7:0] rd;
    r0 = m_rises;
    mosi_glitch = 1'b0;
    run_frame(1'b0, 6'h2D, 8'h08, t_cs, t_sck, t_sck2, t_rise,
              t_rsp, n_rsp, t_rdy, cs_low, rd);
    checks++;
    if (m_frame !== 16'h2D08) begin
      errors++; $display("FAIL wr_frame: got %h want 2d08", m_frame);
    end
    checks++;
    if (cs_low != 136) begin
      errors++; $display("FAIL wr_cs_low: got %0d want 136", cs_low);
    end
    checks++;
    if (m_rises - r0 != 16) begin
      errors++;
      $display("FAIL wr_rises: got %0d want 16", m_rises - r0);
    end
    checks++;
    if (mosi_glitch !== 1'b0) begin
      errors++; $display("FAIL wr_mosi_edge: got %b want 0",
                         mosi_glitch);
    end
    checks++;
    if (n_rsp != 1) begin
      errors++; $display("FAIL wr_rsp: got %0d want 1", n_rsp);
    end
    run_frame(1'b1, 6'h2D, 8'h00, t_cs, t_sck, t_sck2, t_rise,
              t_rsp, n_rsp, t_rdy, cs_low, rd);
    checks++;
    if (rd !== 8'h08 || m_frame !== 16'hAD00) begin
      errors++;
      $display("FAIL wr_readback: got %h/%h want 08/ad00",
               rd, m_frame);
    end
  endtask

  task automatic test_back_to_back;
    int   n_p, t_rise1, t_fall2;
    logic pc;
    n_p = 0; t_rise1 = -1; t_fall2 = -1; pc = 1'b1;
    dbl_rsp = 1'b0;
    @(negedge clk);
    req_rw = 1'b1; req_addr = 6'h00; req_wdata = 8'h00;
    req_valid = 1'b1;
    for (int n = 0; n < 800 && !(n_p == 2 && ready); n++) begin
      @(negedge clk);
      if (!pc && m_cs && t_rise1 < 0) t_rise1 = n;
      if (pc && !m_cs && t_rise1 >= 0 && t_fall2 < 0) begin
        t_fall2 = n;
        req_valid = 1'b0;
      end
      if (rsp_v) n_p++;
      pc = m_cs;
    end
    req_valid = 1'b0;
    checks++;
    if (n_p != 2) begin
      errors++; $display("FAIL b2b_pulses: got %0d want 2", n_p);
    end
    checks++;
    if (t_rise1 < 0 || t_fall2 < 0 || t_fall2 - t_rise1 < 5) begin
      errors++;
      $display("FAIL b2b_gap: got %0d want >=5", t_fall2 - t_rise1);
    end
    checks++;
    if (dbl_rsp !== 1'b0 || rdata !== 8'hE5) begin
      errors++;
      $display("FAIL b2b_rsp: got dbl=%b data=%h want 0/e5",
               dbl_rsp, rdata);
    end
  endtask

  task automatic test_reset_midframe;
    int t_cs, t_sck, t_sck2, t_rise, t_rsp, n_rsp, t_rdy, cs_low;
    int r0, p0, t;
    logic [7:0] rd;
    r0 = m_rises;
    p0 = rsp_total;
    @(negedge clk);
    req_rw = 1'b1; req_addr = 6'h00; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int n = 0; n < 400 && m_rises - r0 < 5; n++)
      @(negedge clk);
    checks++;
    if (m_rises - r0 != 5) begin
      errors++;
      $display("FAIL mid_rises: got %0d want 5", m_rises - r0);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (m_cs !== 1'b1 || m_sck !== 1'b1 || rsp_v !== 1'b0) begin
      errors++;
      $display("FAIL mid_async: got cs=%b sck=%b rsp=%b want 1/1/0",
               m_cs, m_sck, rsp_v);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_ready(t);
    checks++;
    if (t < 0 || rsp_total != p0) begin
      errors++;
      $display("FAIL mid_no_rsp: got t=%0d rsp=%0d want >=0/%0d",
               t, rsp_total - p0, 0);
    end
    run_frame(1'b1, 6'h00, 8'h00, t_cs, t_sck, t_sck2, t_rise,
              t_rsp, n_rsp, t_rdy, cs_low, rd);
    checks++;
    if (rd !== 8'hE5 || n_rsp != 1 || m_frame !== 16'h8000) begin
      errors++;
      $display("FAIL mid_recover: got %h n=%0d want e5/1", rd, n_rsp);
    end
  endtask

  task automatic test_devid;
`ifdef ADXL345_SPI_DEVID_CHECK_EN
    int t;
    m_regs[0] = 8'h00;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    wait_ready(t);
    checks++;
    if (t != 141 || dev_err !== 1'b1 || dev_ok !== 1'b0) begin
      errors++;
      $display("FAIL devid_err: got t=%0d ok=%b err=%b want 141/0/1",
               t, dev_ok, dev_err);
    end
    m_regs[0] = 8'hE5;
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    wait_ready(t);
    checks++;
    if (dev_ok !== 1'b1 || dev_err !== 1'b0) begin
      errors++;
      $display("FAIL devid_ok: got ok=%b err=%b want 1/0",
               dev_ok, dev_err);
    end
`else
    checks++;
    if (dev_ok !== 1'b0 || dev_err !== 1'b0) begin
      errors++;
      $display("FAIL devid_tied: got ok=%b err=%b want 0/0",
               dev_ok, dev_err);
    end
`endif
  endtask

  task automatic test_clkdiv2;
    int t;
    @(negedge clk);
    use2 = 1'b1;
    rst2_n = 1'b1;
    wait_ready(t);
    checks++;
    if (t != (BOOT_EN ? 1 + 35 * 2 : 0)) begin
      errors++;
      $display("FAIL div2_ready: got %0d want %0d",
               t, BOOT_EN ? 71 : 0);
    end
    checks++;
    if (dev_ok !== BOOT_EN) begin
      errors++;
      $display("FAIL div2_dev: got %b want %b", dev_ok, BOOT_EN);
    end
    test_read(2, 2);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) m_regs[i] = 8'(i);
    m_regs[0] = 8'hE5;
    test_reset();
    test_read(4, 4);
    test_write();
    test_back_to_back();
    test_reset_midframe();
    test_devid();
    test_clkdiv2();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
